// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer and the unit benches:
// FSM state encoding and the default iteration counts.
package muldiv_pkg;

  // FSM state encoding (2 bits, legacy-compatible numeric values)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Multiplier needs 33 iterations plus one output cycle; divider matches
  localparam int MULT_CYCLES_DEF = 34;
  localparam int DIV_CYCLES_DEF  = 34;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multi-cycle multiply/divide units and owner of the
// architectural HI/LO registers. Holds the unit enable for a fixed number of
// cycles, captures the result into HI/LO, and stalls the CPU via busy.
// All status outputs decode from registered state only.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = muldiv_pkg::MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = muldiv_pkg::DIV_CYCLES_DEF,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        divisor_zero,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  output logic        multOp,
  output logic        divOp,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Counter value on the final cycle of each operation
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [31:0]      hi_reg,    hi_next;
  logic [31:0]      lo_reg,    lo_next;
  logic             div0_reg,  div0_next;

  // Next-state, counter and HI/LO update logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    div0_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // MTHI/MTLO only land while idle; a coincident start is still taken
        if (hi_we) hi_next = hi_wdata;
        if (lo_we) lo_next = lo_wdata;
        if (start_mult) begin
          // MULT has priority over a simultaneous DIV request
          state_next = S_MULT;
          cnt_next   = '0;
        end else if (start_div) begin
          if (divisor_zero) begin
            // Skip the divider entirely; HI/LO are left untouched
            state_next = S_DONE;
            div0_next  = 1'b1;
          end else begin
            state_next = S_DIV;
            cnt_next   = '0;
          end
        end
      end
      S_MULT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == MULT_LAST) begin
          hi_next    = mult_hi;
          lo_next    = mult_lo;
          state_next = S_DONE;
        end
      end
      S_DIV: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == DIV_LAST) begin
          hi_next    = div_hi;   // remainder
          lo_next    = div_lo;   // quotient
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Starts arriving here are dropped, not queued
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation and clears HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      div0_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      div0_reg  <= div0_next;
    end
  end

  assign multOp = (state_reg == S_MULT);
  assign divOp  = (state_reg == S_DIV);
  assign busy   = (state_reg == S_MULT) || (state_reg == S_DIV);
  assign done   = (state_reg == S_DONE);
  assign div0   = div0_reg;
  assign hi     = hi_reg;
  assign lo     = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: one task per scenario, expectations are
// hand-computed from the cycle timing of the sequencer.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MC = MULT_CYCLES_DEF;
  localparam int DC = DIV_CYCLES_DEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult, start_div, divisor_zero;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;
  logic        multOp, divOp, busy, done, div0;
  logic [31:0] hi, lo;

  int tests_run = 0;
  int tests_failed = 0;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .start_mult(start_mult), .start_div(start_div), .divisor_zero(divisor_zero),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .multOp(multOp), .divOp(divOp), .busy(busy), .done(done), .div0(div0),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs driven after this are sampled at the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_mult = 0; start_div = 0; divisor_zero = 0;
    hi_we = 0; lo_we = 0; hi_wdata = 0; lo_wdata = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    mult_hi = 0; mult_lo = 0; div_hi = 0; div_lo = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    tests_run++;
    if ({multOp, divOp, busy, done, div0} !== 5'b0 || hi !== 0 || lo !== 0) begin
      tests_failed++;
      $display("FAIL reset: ops/busy/done/div0=%b hi=%h lo=%h, required 00000 0 0",
               {multOp, divOp, busy, done, div0}, hi, lo);
    end
    $display("[TB] reset checked");
  endtask

  // MULT 3 * -5 with an LO write coinciding with the start
  task automatic test_mult();
    mult_hi = 32'hFFFF_FFFF; mult_lo = 32'hFFFF_FFF1;
    start_mult = 1; lo_we = 1; lo_wdata = 32'h0000_0077;
    tick();  // cycle 1
    start_mult = 0; lo_we = 0;
    tests_run++;
    if (lo !== 32'h77) begin
      tests_failed++;
      $display("FAIL mult_coincident_write: lo=%h required 00000077", lo);
    end
    for (int c = 1; c <= MC; c++) begin
      tests_run++;
      if (busy !== 1 || multOp !== 1 || divOp !== 0 || done !== 0) begin
        tests_failed++;
        $display("FAIL mult_busy cycle %0d: busy=%b multOp=%b divOp=%b done=%b required 1 1 0 0",
                 c, busy, multOp, divOp, done);
      end
      tick();
    end
    tests_run++;
    if (done !== 1 || busy !== 0 || multOp !== 0 || div0 !== 0 ||
        hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      tests_failed++;
      $display("FAIL mult_done: done=%b busy=%b multOp=%b div0=%b hi=%h lo=%h required 1 0 0 0 ffffffff fffffff1",
               done, busy, multOp, div0, hi, lo);
    end
    tick();
    tests_run++;
    if (done !== 0 || busy !== 0) begin
      tests_failed++;
      $display("FAIL mult_after: done=%b busy=%b required 0 0", done, busy);
    end
    $display("[TB] mult 3*-5 -> hi=%h lo=%h", hi, lo);
  endtask

  // DIV 7/2: quotient 3, remainder 1
  task automatic test_div();
    div_hi = 32'd1; div_lo = 32'd3;
    start_div = 1; divisor_zero = 0;
    tick();
    start_div = 0;
    for (int c = 1; c <= DC; c++) begin
      tests_run++;
      if (busy !== 1 || divOp !== 1 || multOp !== 0 || done !== 0) begin
        tests_failed++;
        $display("FAIL div_busy cycle %0d: busy=%b divOp=%b multOp=%b done=%b required 1 1 0 0",
                 c, busy, divOp, multOp, done);
      end
      tick();
    end
    tests_run++;
    if (done !== 1 || div0 !== 0 || multOp !== 0 || hi !== 32'd1 || lo !== 32'd3) begin
      tests_failed++;
      $display("FAIL div_done: done=%b div0=%b multOp=%b hi=%h lo=%h required 1 0 0 00000001 00000003",
               done, div0, multOp, hi, lo);
    end
    tick();
    $display("[TB] div 7/2 -> hi=%h lo=%h", hi, lo);
  endtask

  // Divide by zero with preloaded HI/LO
  task automatic test_div_zero();
    hi_we = 1; lo_we = 1; hi_wdata = 32'hAAAA; lo_wdata = 32'h5555;
    tick();
    hi_we = 0; lo_we = 0;
    tests_run++;
    if (hi !== 32'hAAAA || lo !== 32'h5555) begin
      tests_failed++;
      $display("FAIL div0_preload: hi=%h lo=%h required 0000aaaa 00005555", hi, lo);
    end
    div_hi = 32'hDEAD; div_lo = 32'hBEEF;
    start_div = 1; divisor_zero = 1;
    tick();  // cycle 1
    start_div = 0; divisor_zero = 0;
    tests_run++;
    if (div0 !== 1 || done !== 1 || busy !== 0 || divOp !== 0 ||
        hi !== 32'hAAAA || lo !== 32'h5555) begin
      tests_failed++;
      $display("FAIL div0_pulse: div0=%b done=%b busy=%b divOp=%b hi=%h lo=%h required 1 1 0 0 0000aaaa 00005555",
               div0, done, busy, divOp, hi, lo);
    end
    for (int c = 2; c <= 6; c++) begin
      tick();
      tests_run++;
      if (div0 !== 0 || done !== 0 || busy !== 0 || hi !== 32'hAAAA || lo !== 32'h5555) begin
        tests_failed++;
        $display("FAIL div0_after cycle %0d: div0=%b done=%b busy=%b hi=%h lo=%h required 0 0 0 0000aaaa 00005555",
                 c, div0, done, busy, hi, lo);
      end
    end
    $display("[TB] div by zero -> hi=%h lo=%h", hi, lo);
  endtask

  // Simultaneous start_mult and start_div: MULT wins, DIV dropped
  task automatic test_simultaneous();
    mult_hi = 32'h0000_0000; mult_lo = 32'h0000_0015;  // 3*7
    div_hi = 32'h1111_1111; div_lo = 32'h2222_2222;
    start_mult = 1; start_div = 1;
    tick();
    start_mult = 0; start_div = 0;
    for (int c = 1; c <= MC; c++) begin
      tests_run++;
      if (multOp !== 1 || divOp !== 0) begin
        tests_failed++;
        $display("FAIL simul_ops cycle %0d: multOp=%b divOp=%b required 1 0", c, multOp, divOp);
      end
      tick();
    end
    tests_run++;
    if (done !== 1 || hi !== 32'h0 || lo !== 32'h15) begin
      tests_failed++;
      $display("FAIL simul_done: done=%b hi=%h lo=%h required 1 00000000 00000015", done, hi, lo);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (divOp !== 0 || busy !== 0) begin
        tests_failed++;
        $display("FAIL simul_no_div: divOp=%b busy=%b required 0 0", divOp, busy);
      end
    end
    $display("[TB] simultaneous start -> lo=%h", lo);
  endtask

  // Reset at cycle 10 of a MULT aborts it
  task automatic test_reset_mid();
    hi_we = 1; lo_we = 1; hi_wdata = 32'h1357; lo_wdata = 32'h2468;
    tick();
    hi_we = 0; lo_we = 0;
    mult_hi = 32'h9999; mult_lo = 32'h8888;
    start_mult = 1;
    tick();  // cycle 1
    start_mult = 0;
    for (int c = 1; c < 10; c++) tick();  // now in cycle 10
    tests_run++;
    if (multOp !== 1 || hi !== 32'h1357) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: multOp=%b hi=%h required 1 00001357", multOp, hi);
    end
    reset = 1;
    tick();  // cycle 11
    reset = 0;
    tests_run++;
    if (multOp !== 0 || busy !== 0 || done !== 0 || hi !== 0 || lo !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid: multOp=%b busy=%b done=%b hi=%h lo=%h required 0 0 0 0 0",
               multOp, busy, done, hi, lo);
    end
    for (int c = 12; c <= 45; c++) begin
      tick();
      tests_run++;
      if (done !== 0 || busy !== 0 || hi !== 0) begin
        tests_failed++;
        $display("FAIL rst_mid_no_done cycle %0d: done=%b busy=%b hi=%h required 0 0 0", c, done, busy, hi);
      end
    end
    $display("[TB] reset mid-mult -> hi=%h lo=%h", hi, lo);
  endtask

  // MTHI ignored while busy; held start does not restart; MTHI in IDLE lands
  task automatic test_write_busy();
    mult_hi = 32'h0000_00AB; mult_lo = 32'h0000_00CD;
    start_mult = 1;
    tick();  // cycle 1; start_mult stays held through the operation
    for (int c = 1; c <= MC; c++) begin
      if (c == 5) begin hi_we = 1; hi_wdata = 32'h1234; end
      else hi_we = 0;
      tests_run++;
      if (busy !== 1 || done !== 0) begin
        tests_failed++;
        $display("FAIL held_start cycle %0d: busy=%b done=%b required 1 0", c, busy, done);
      end
      if (c == 6) begin
        tests_run++;
        if (hi !== 32'h0) begin
          tests_failed++;
          $display("FAIL mthi_busy: hi=%h required 00000000", hi);
        end
      end
      tick();
    end
    hi_we = 0;
    start_mult = 0;  // dropped during DONE; held start in DONE is ignored
    tests_run++;
    if (done !== 1 || hi !== 32'hAB || lo !== 32'hCD) begin
      tests_failed++;
      $display("FAIL held_done: done=%b hi=%h lo=%h required 1 000000ab 000000cd", done, hi, lo);
    end
    tick();
    tests_run++;
    if (busy !== 0 || multOp !== 0) begin
      tests_failed++;
      $display("FAIL held_no_restart: busy=%b multOp=%b required 0 0", busy, multOp);
    end
    hi_we = 1; hi_wdata = 32'h1234;
    tick();
    hi_we = 0;
    tests_run++;
    if (hi !== 32'h1234 || lo !== 32'hCD) begin
      tests_failed++;
      $display("FAIL mthi_idle: hi=%h lo=%h required 00001234 000000cd", hi, lo);
    end
    $display("[TB] mthi/held start -> hi=%h lo=%h", hi, lo);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_simultaneous();
    test_reset_mid();
    test_write_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
